// File: rtl/cpu_memory.sv
// Moxie memory-access stage: drives the data-memory req/ack bus and the register-file write port.
// Optional macro CPU_MEM_TIMEOUT_EN bounds the wait for dmem_ack_i to TIMEOUT_CYCLES.
module cpu_memory #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  register_write_index_i,
    input  logic        register_write_enable_i,
    input  logic        memory_write_enable_i,
    input  logic        memory_read_enable_i,
    input  logic [31:0] memory_address_i,
    input  logic [31:0] result_i,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_data_i,
    output logic        stall_o,
    output logic [3:0]  register_write_index_o,
    output logic        register_write_enable_o,
    output logic [31:0] result_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_data_o,
    output logic        mem_error_o
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] result_q, result_d;
    logic [3:0]  rwi_q, rwi_d;
    logic        rwe_q, rwe_d;
    logic [3:0]  ld_idx_q, ld_idx_d;

`ifdef CPU_MEM_TIMEOUT_EN
    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        result_d = result_q;
        rwi_d    = rwi_q;
        rwe_d    = 1'b0;
        ld_idx_d = ld_idx_q;
`ifdef CPU_MEM_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (memory_write_enable_i) begin
                    // Store takes priority over a simultaneous load
                    addr_d  = memory_address_i;
                    wdata_d = result_i;
                    we_d    = 1'b1;
                    req_d   = 1'b1;
                    state_d = ACCESS;
`ifdef CPU_MEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else if (memory_read_enable_i) begin
                    addr_d   = memory_address_i;
                    we_d     = 1'b0;
                    req_d    = 1'b1;
                    ld_idx_d = register_write_index_i;
                    state_d  = ACCESS;
`ifdef CPU_MEM_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end else begin
                    result_d = result_i;
                    rwe_d    = register_write_enable_i;
                    rwi_d    = register_write_index_i;
                end
            end
            ACCESS: begin
                if (dmem_ack_i) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    if (!we_q) begin
                        result_d = dmem_data_i;
                        rwi_d    = ld_idx_q;
                        rwe_d    = 1'b1;
                    end
                end
`ifdef CPU_MEM_TIMEOUT_EN
                else if (cnt_q == LIMIT) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            result_q <= '0;
            rwi_q    <= '0;
            rwe_q    <= 1'b0;
            ld_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            result_q <= result_d;
            rwi_q    <= rwi_d;
            rwe_q    <= rwe_d;
            ld_idx_q <= ld_idx_d;
        end
    end

`ifdef CPU_MEM_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign mem_error_o = err_q;
`else
    assign mem_error_o = 1'b0;
`endif

    assign stall_o                 = (state_q == ACCESS);
    assign dmem_req_o              = req_q;
    assign dmem_we_o               = we_q;
    assign dmem_addr_o             = addr_q;
    assign dmem_data_o             = wdata_q;
    assign result_o                = result_q;
    assign register_write_index_o  = rwi_q;
    assign register_write_enable_o = rwe_q;

endmodule

// File: doc/cpu_memory.md
Name: cpu_memory

Overview:
- Moxie memory-access stage, directly downstream of the execute stage.
- Consumes the execute-stage result, register-write and memory-control outputs, and performs data-memory loads/stores over a req/ack bus.
- Presents a registered write port to the register file.
- Raises stall_o to hold execute and earlier stages while a memory transaction is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, max cycles ACCESS waits for dmem_ack_i before abort (only with CPU_MEM_TIMEOUT_EN); 1..65535

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  reset, asynchronous, active-low (0 = reset)
register_write_index_i  input  4  destination register from execute
register_write_enable_i  input  1  execute requests register write of result_i
memory_write_enable_i  input  1  store request; data = result_i
memory_read_enable_i  input  1  load request; destination = register_write_index_i
memory_address_i  input  32  byte address for load/store
result_i  input  32  ALU result or store data
dmem_ack_i  input  1  data memory completes current access
dmem_data_i  input  32  load data, valid when dmem_ack_i=1
stall_o  output  1  upstream must hold its outputs
register_write_index_o  output  4  register file write index
register_write_enable_o  output  1  register file write strobe, one cycle per write
result_o  output  32  register file write data
dmem_req_o  output  1  access request, held until ack
dmem_we_o  output  1  1 = store, 0 = load; valid with dmem_req_o
dmem_addr_o  output  32  access address
dmem_data_o  output  32  store data
mem_error_o  output  1  one-cycle pulse on aborted access (timeout)

Behaviour:
- Reset (rst_i=0, async): state=IDLE; stall_o, register_write_enable_o, dmem_req_o, dmem_we_o, mem_error_o = 0; register_write_index_o=0; result_o, dmem_addr_o, dmem_data_o = 0; timeout counter=0.
- Reset mid-transaction: dmem_req_o drops immediately (async); no register write is produced for the aborted access.
- States: IDLE, ACCESS. stall_o = (state==ACCESS), decoded from registered state.
- IDLE, no memory enable: pass-through with 1-cycle latency.
  - result_o<=result_i
  - register_write_enable_o<=register_write_enable_i
  - register_write_index_o<=register_write_index_i
- IDLE, memory_write_enable_i=1:
  - latch dmem_addr_o<=memory_address_i, dmem_data_o<=result_i, dmem_we_o<=1, dmem_req_o<=1
  - register_write_enable_o<=0; go to ACCESS
- IDLE, memory_read_enable_i=1 (write enable 0):
  - latch address, dmem_we_o<=0, dmem_req_o<=1
  - latch register_write_index_i internally; register_write_enable_o<=0; go to ACCESS
- Both enables high: store wins, load ignored; register_write_enable_i is ignored whenever either memory enable is high.
- ACCESS, dmem_ack_i=0: hold all dmem_* outputs stable; register_write_enable_o=0; inputs ignored.
- ACCESS, dmem_ack_i=1: dmem_req_o<=0; go to IDLE.
  - Load: result_o<=dmem_data_i, register_write_index_o<=latched index, register_write_enable_o<=1 for one cycle.
  - Store: no register write.
- Minimum memory op: req asserted cycle N+1, ack in N+1, register write visible N+2, stall_o high exactly one cycle (N+1).
- Upstream holds inputs stable while stall_o=1. The cycle after return to IDLE, inputs are sampled as a new operation; back-to-back accesses are legal (IDLE for one cycle between them).
- Addresses passed unmodified, full 32-bit word accesses only; alignment not checked.
- dmem_ack_i outside ACCESS is ignored.

Optional Feature:
- Macro: CPU_MEM_TIMEOUT_EN.
- Enabled:
  - Counter clears on ACCESS entry and increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYCLES: dmem_req_o<=0, mem_error_o pulses 1 cycle, no register write, return to IDLE.
  - Ack on the same cycle the limit is reached: ack wins, normal completion.
- Disabled: no counter logic; ACCESS waits indefinitely; mem_error_o tied to 0.

Test Plan:
- Reset: rst_i=0 during an outstanding req -> dmem_req_o=0 at once; all outputs 0; state IDLE after release.
- ALU pass-through: result_i=0x12345678, index=3, wr_en=1 -> next cycle result_o=0x12345678, index_o=3, wr_en_o=1; stall_o stays 0.
- Store with 3-cycle ack delay: addr=0x1000, result_i=0xDEADBEEF -> req/we=1, addr/data held for 3 cycles, stall_o=1 for 3 cycles, no register write.
- Load with zero-wait ack: addr=0x2000, index=5, dmem_data_i=0xCAFEF00D -> stall_o high 1 cycle; next cycle wr_en_o=1, index_o=5, result_o=0xCAFEF00D.
- Both enables high: load+store on addr 0x40 -> store performed (we=1), no register write.
- CPU_MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never arrives -> req drops after 4 ACCESS cycles, mem_error_o=1 for one cycle, stall_o=0 afterward.
